// File: rtl/wg_sequencer.sv
// ============================================================================
// wg_sequencer
// ----------------------------------------------------------------------------
// Playlist controller for the waveform generator. Holds up to DEPTH segment
// entries {dur, freq, amp, wave} and plays them in order. Each segment drives
// wave_sel/amp_sel/freqinit for max(dur,1)*PRESCALE clock cycles. The next
// segment is loaded on the edge that ends the current one, so there is no gap.
//
// Optional feature macro: SEQ_LOOP_EN
//   defined   : after the final segment, done pulses and playback wraps to
//               entry 0 on the same edge, running until stop or reset.
//   undefined : one-shot playback that returns to IDLE after the final segment.
//
// Ports
//   clk       in   1          system clock, rising edge
//   rst       in   1          asynchronous reset, active low
//   start     in   1          begins playback from entry 0 when idle
//   stop      in   1          aborts playback; wins over start and segment end
//   wr_en     in   1          playlist write strobe
//   wr_addr   in   AW         playlist write address
//   wr_data   in   DUR_W+10   {dur[DUR_W-1:0], freq[4:0], amp[1:0], wave[2:0]}
//   last_idx  in   AW         index of the final entry, sampled on start
//   wave_sel  out  3          generator wave mux select
//   amp_sel   out  2          generator amplitude select
//   freqinit  out  5          generator frequency divider init
//   seg_idx   out  AW         index of the entry currently driven
//   busy      out  1          high while playing
//   done      out  1          one-cycle pulse after the final segment ends
// ============================================================================
module wg_sequencer #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int DUR_W    = 8,
    parameter int PRESCALE = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DUR_W+9:0]  wr_data,
    input  logic [AW-1:0]     last_idx,
    output logic [2:0]        wave_sel,
    output logic [1:0]        amp_sel,
    output logic [4:0]        freqinit,
    output logic [AW-1:0]     seg_idx,
    output logic              busy,
    output logic              done
);

    localparam int EW = DUR_W + 10;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    // One bit per encodable address, set where the address names a real entry.
    // Lets a non-power-of-2 DEPTH reject writes and clamp last_idx by lookup.
    function automatic logic [(1<<AW)-1:0] valid_mask();
        logic [(1<<AW)-1:0] m;
        m = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            if (i < DEPTH) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [(1<<AW)-1:0] ADDR_OK = valid_mask();

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [EW-1:0]     mem [DEPTH];
    logic [PW-1:0]     pre_cnt;
    logic [DUR_W-1:0]  tick_cnt;
    logic [DUR_W-1:0]  cur_dur;
    logic [AW-1:0]     last_q;

    logic [AW-1:0]     next_idx;
    logic [AW-1:0]     last_clamp;
    logic [DUR_W-1:0]  tick_last;
    logic              seg_end;
    logic              at_last;
    logic              wr_ok;
    logic [EW-1:0]     load_e;

    assign next_idx   = seg_idx + AW'(1);
    assign last_clamp = ADDR_OK[last_idx] ? last_idx : AW'(DEPTH - 1);
    assign wr_ok      = wr_en && ADDR_OK[wr_addr];
    assign at_last    = (seg_idx == last_q);

    // dur=0 is treated as a one-tick segment, so its final tick index is 0.
    assign tick_last  = (cur_dur == '0) ? '0 : cur_dur - DUR_W'(1);
    assign seg_end    = (pre_cnt == PRE_LAST) && (tick_cnt == tick_last);

    // Entry to load on the next transition: the following entry while a
    // non-final segment plays, otherwise entry 0 (start, or loop wrap).
    assign load_e = (state == RUN && !at_last) ? mem[next_idx] : mem[0];

    // Playlist storage, FSM, counters and registered outputs. Loads read the
    // pre-edge memory contents, so a same-edge write to that entry is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wave_sel <= '0;
            amp_sel  <= '0;
            freqinit <= '0;
            seg_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            cur_dur  <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        last_q   <= last_clamp;
                        seg_idx  <= '0;
                        wave_sel <= load_e[2:0];
                        amp_sel  <= load_e[4:3];
                        freqinit <= load_e[9:5];
                        cur_dur  <= load_e[EW-1:10];
                        pre_cnt  <= '0;
                        tick_cnt <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        pre_cnt  <= '0;
                        tick_cnt <= '0;
                    end else if (seg_end) begin
                        pre_cnt  <= '0;
                        tick_cnt <= '0;
                        if (at_last) begin
                            done <= 1'b1;
`ifdef SEQ_LOOP_EN
                            seg_idx  <= '0;
                            wave_sel <= load_e[2:0];
                            amp_sel  <= load_e[4:3];
                            freqinit <= load_e[9:5];
                            cur_dur  <= load_e[EW-1:10];
`else
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end else begin
                            seg_idx  <= next_idx;
                            wave_sel <= load_e[2:0];
                            amp_sel  <= load_e[4:3];
                            freqinit <= load_e[9:5];
                            cur_dur  <= load_e[EW-1:10];
                        end
                    end else if (pre_cnt == PRE_LAST) begin
                        pre_cnt  <= '0;
                        tick_cnt <= tick_cnt + DUR_W'(1);
                    end else begin
                        pre_cnt <= pre_cnt + PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule
